// File: rtl/sa_fault_pkg.sv
// Shared types and defaults for the stuck-at fault response analyser.
// Holds the sweep FSM state encoding and the default N_IN / SETTLE values.
// No logic here; imported by the interface, the settle timer and the top.
package sa_fault_pkg;

    localparam int N_IN_DEF   = 3;
    localparam int SETTLE_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COMPARE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sa_fault_detector_if.sv
// Bundle between the analyser, the good/faulty circuit pair and the controller.
// slave: analyser side (drives the vector and results); master: environment side.
// No storage; pure wiring with direction checks via modports.
interface sa_fault_detector_if
    import sa_fault_pkg::*;
#(
    parameter int N_IN = N_IN_DEF
);

    logic                 start;
    logic                 f_good;
    logic                 f_fault;
    logic [N_IN-1:0]      vec_out;
    logic                 busy;
    logic                 done;
    logic                 detected;
    logic [2**N_IN-1:0]   detect_mask;
    logic [N_IN-1:0]      first_vec;
    logic [N_IN:0]        det_count;

    modport slave (
        input  start, f_good, f_fault,
        output vec_out, busy, done, detected, detect_mask, first_vec, det_count
    );

    modport master (
        output start, f_good, f_fault,
        input  vec_out, busy, done, detected, detect_mask, first_vec, det_count
    );

endinterface

// File: rtl/sa_settle_timer.sv
// Loadable down-counter that times how long each vector is held before compare.
// Latency: load takes effect next cycle; zero flag is a decode of the register.
// No backpressure: load has priority over dec, and dec stops at zero.
module sa_settle_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: reload, or decrement while non-zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/sa_fault_detector.sv
// Sweeps all 2**N_IN vectors into a good/faulty pair and records detecting vectors.
// Latency: SETTLE+1 cycles per vector; done 2**N_IN*(SETTLE+1) cycles after start.
// start is only honoured in IDLE/DONE; SA_EARLY_STOP_EN stops at the first detection.
module sa_fault_detector
    import sa_fault_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    sa_fault_detector_if.slave    bus
);

    localparam int              NV       = 2**N_IN;
    localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   RELOAD   = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] VEC_LAST = '1;

    state_t            state_q,  state_d;
    logic [N_IN-1:0]   vec_q,    vec_d;
    logic [NV-1:0]     mask_q,   mask_d;
    logic [N_IN-1:0]   first_q,  first_d;
    logic [N_IN:0]     count_q,  count_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;

    logic              tmr_load;
    logic              tmr_dec;
    logic              tmr_zero;
    logic              mis;

    sa_settle_timer #(
        .W (CW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (RELOAD),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Sweep FSM, vector counter and result capture (next-state side).
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        mask_d   = mask_q;
        first_d  = first_q;
        count_d  = count_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        mis      = bus.f_good ^ bus.f_fault;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d  = ST_SETTLE;
                    vec_d    = '0;
                    mask_d   = '0;
                    first_d  = '0;
                    count_d  = '0;
                    tmr_load = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    state_d = ST_COMPARE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_COMPARE: begin
                if (mis) begin
                    mask_d[vec_q] = 1'b1;
                    count_d       = count_q + (N_IN+1)'(1);
                    if (count_q == '0) begin
                        first_d = vec_q;
                    end
                end
`ifdef SA_EARLY_STOP_EN
                if (mis || (vec_q == VEC_LAST)) begin
                    state_d = ST_DONE;
                end else begin
                    vec_d    = vec_q + N_IN'(1);
                    tmr_load = 1'b1;
                    state_d  = ST_SETTLE;
                end
`else
                if (vec_q == VEC_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    vec_d    = vec_q + N_IN'(1);
                    tmr_load = 1'b1;
                    state_d  = ST_SETTLE;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags are registered from the next state so they align with it.
        busy_d = (state_d == ST_SETTLE) || (state_d == ST_COMPARE);
        done_d = (state_d == ST_DONE);
    end

    // State and result registers; reset aborts any sweep in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            mask_q  <= '0;
            first_q <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            mask_q  <= mask_d;
            first_q <= first_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.vec_out     = vec_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.detected    = |mask_q;
    assign bus.detect_mask = mask_q;
    assign bus.first_vec   = first_q;
    assign bus.det_count   = count_q;

endmodule

// File: tb/tb_sa_fault_detector.sv
// Bench for sa_fault_detector: good circuit F0=(A&B)|C, faulty circuit from a truth table.
// Fixed and random fault tables checked against a truth-table sweep model.
// Hand sequences cover reset, mid-sweep reset, start while busy and start in DONE.
module tb_sa_fault_detector;

    localparam int N_IN   = 3;
    localparam int SETTLE = 2;
    localparam int NV     = 8;
    localparam int PER    = SETTLE + 1;
    localparam int NRAND  = 20;

    typedef struct {
        logic [7:0] tt;
        logic [7:0] mask;
        logic [3:0] cnt;
        logic [2:0] first;
        logic [2:0] vec;
        int         cycles;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [7:0] tt_cur;
    int         n_vec;
    int         n_bad;

    sa_fault_detector_if #(.N_IN(N_IN)) bus ();

    sa_fault_detector #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Circuit pair: fixed good function, faulty output looked up from tt_cur.
    always_comb begin
        bus.f_good  = (bus.vec_out[2] & bus.vec_out[1]) | bus.vec_out[0];
        bus.f_fault = tt_cur[bus.vec_out];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Expected results from walking the truth tables vector by vector.
    function automatic vec_t model(input logic [7:0] tt);
        vec_t r;
        r.tt     = tt;
        r.mask   = '0;
        r.cnt    = '0;
        r.first  = '0;
        r.vec    = 3'd7;
        r.cycles = NV * PER;
        for (int v = 0; v < NV; v++) begin
            logic [2:0] a;
            logic       g;
            a = 3'(v);
            g = (a[2] & a[1]) | a[0];
            if (g != tt[v]) begin
                if (r.cnt == 0) r.first = a;
                r.mask[v] = 1'b1;
                r.cnt     = r.cnt + 4'd1;
`ifdef SA_EARLY_STOP_EN
                r.vec    = a;
                r.cycles = (v + 1) * PER;
                break;
`endif
            end
        end
        return r;
    endfunction

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"},  32'(bus.busy), 0);
        chk({tag, "_done"},  32'(bus.done), 0);
        chk({tag, "_det"},   32'(bus.detected), 0);
        chk({tag, "_mask"},  32'(bus.detect_mask), 0);
        chk({tag, "_first"}, 32'(bus.first_vec), 0);
        chk({tag, "_count"}, 32'(bus.det_count), 0);
        chk({tag, "_vec"},   32'(bus.vec_out), 0);
    endtask

    task automatic run_sweep(input vec_t t, input bit repulse);
        int cyc;
        tt_cur = t.tt;
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                chk("busy_early", 32'(bus.busy), 1);
                chk("mask_cleared", 32'(bus.detect_mask), 0);
            end
            if (repulse && cyc == 5) bus.start = 1'b1;
            if (repulse && cyc == 6) bus.start = 1'b0;
        end
        chk("done_cycles", 32'(cyc), 32'(t.cycles));
        chk("mask",  32'(bus.detect_mask), 32'(t.mask));
        chk("count", 32'(bus.det_count), 32'(t.cnt));
        chk("first", 32'(bus.first_vec), 32'(t.first));
        chk("det",   32'(bus.detected), 32'(t.mask != 0));
        chk("vec",   32'(bus.vec_out), 32'(t.vec));
        chk("busy_done", 32'(bus.busy), 0);
        // Results must hold while sitting in DONE.
        repeat (3) @(posedge clk);
        #1;
        chk("hold_mask", 32'(bus.detect_mask), 32'(t.mask));
        chk("hold_done", 32'(bus.done), 1);
    endtask

    vec_t tbl [NRAND + 3];

    initial begin
        int k;
        n_vec     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        tt_cur    = 8'h00;

        // Faulty truth tables: B stuck-at-1 (A|C), fault-free copy, output stuck at 1.
`ifdef SA_EARLY_STOP_EN
        tbl[0] = '{tt: 8'b1111_1010, mask: 8'b0001_0000, cnt: 4'd1, first: 3'd4, vec: 3'd4, cycles: 15};
        tbl[1] = '{tt: 8'b1110_1010, mask: 8'b0000_0000, cnt: 4'd0, first: 3'd0, vec: 3'd7, cycles: 24};
        tbl[2] = '{tt: 8'b1111_1111, mask: 8'b0000_0001, cnt: 4'd1, first: 3'd0, vec: 3'd0, cycles: 3};
`else
        tbl[0] = '{tt: 8'b1111_1010, mask: 8'b0001_0000, cnt: 4'd1, first: 3'd4, vec: 3'd7, cycles: 24};
        tbl[1] = '{tt: 8'b1110_1010, mask: 8'b0000_0000, cnt: 4'd0, first: 3'd0, vec: 3'd7, cycles: 24};
        tbl[2] = '{tt: 8'b1111_1111, mask: 8'b0001_0101, cnt: 4'd3, first: 3'd0, vec: 3'd7, cycles: 24};
`endif
        for (int i = 3; i < NRAND + 3; i++) begin
            tbl[i] = model(8'($urandom));
        end

        repeat (3) @(posedge clk);
        #1;
        chk_idle_zero("reset");
        rst = 1'b0;

        // Back-to-back sweeps: each one after the first starts from DONE.
        for (int i = 0; i < NRAND + 3; i++) begin
            run_sweep(tbl[i], 1'b0);
        end

        // Reset with start asserted ten cycles into a sweep.
        tt_cur = 8'b1111_1111;
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        k = 0;
        repeat (10) begin
            @(posedge clk); #1;
            k++;
        end
        chk("mid_mask_nonzero", 32'(bus.detect_mask != 0), 1);
        rst       = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        chk_idle_zero("midrst");
        @(posedge clk); #1;
        chk("midrst_stay_idle", 32'(bus.busy), 0);

        // Clean sweep after the abort, then one with start re-pulsed while busy.
        run_sweep(tbl[0], 1'b0);
        run_sweep(tbl[2], 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
